// File: rtl/prbs_checker.sv
// PRBS word checker: acquires lock on a 32-bit PRBS stream (SEARCH -> VERIFY
// -> LOCKED), then free-runs its own prediction and counts mispredicted words
// and bits while locked.
//
// Optional feature: define PRBS_CHECKER_BITCNT_EN to build the mismatched-bit
// counter; without it err_bit_cnt is tied to zero and no popcount is built.
//
// Input handshake: din is consumed on every rising clk edge where din_valid=1.
// There is no backpressure. Every output is registered and reflects a sampled
// word one cycle later. Cycles with din_valid=0 hold all state and force
// err_pulse low.
module prbs_checker #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] din,
    input  logic        din_valid,
    input  logic        clr_cnt,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_word_cnt,
    output logic [31:0] err_bit_cnt,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_TGT = 4'(LOSS_CNT);

    // One step of the PRBS sequence: a shift right with feedback taps at bits 0, 1 and 21.
    function automatic logic [31:0] prbs_next(input logic [31:0] q);
        logic [31:0] n;
        n     = {q[0], q[31:1]};
        n[0]  = q[1] ^ q[0];
        n[1]  = q[2] ^ q[0];
        n[21] = q[22] ^ q[0];
        return n;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] ref_q, ref_d;
    logic [3:0]  match_q, match_d;
    logic [3:0]  miss_q, miss_d;
    logic        locked_q, locked_d;
    logic        pulse_q, pulse_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic [31:0] pred;
    logic        hit;

    assign pred = prbs_next(ref_q);
    assign hit  = (din == pred);

`ifdef PRBS_CHECKER_BITCNT_EN
    logic [31:0] bcnt_q, bcnt_d;
    logic [32:0] bsum;

    // Number of set bits in a 32-bit word.
    function automatic logic [5:0] popcount(input logic [31:0] x);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + 6'(x[i]);
        end
        return c;
    endfunction

    assign bsum = {1'b0, bcnt_q} + 33'(popcount(din ^ pred));
`endif

    // Next-state, reference, counter and output decode for the current cycle.
    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        match_d = match_q;
        miss_d  = miss_q;
        pulse_d = 1'b0;
        wcnt_d  = wcnt_q;
`ifdef PRBS_CHECKER_BITCNT_EN
        bcnt_d  = bcnt_q;
`endif
        if (din_valid) begin
            case (state_q)
                SEARCH: begin
                    // An all-zero word can never seed a PRBS, so it is ignored.
                    if (din != '0) begin
                        ref_d   = din;
                        match_d = '0;
                        state_d = VERIFY;
                    end
                end
                VERIFY: begin
                    if (hit) begin
                        ref_d   = din;
                        match_d = match_q + 4'd1;
                        if (match_q + 4'd1 == LOCK_TGT) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end else if (din != '0) begin
                        // Re-seed from the new word instead of dropping back.
                        ref_d   = din;
                        match_d = '0;
                    end else begin
                        match_d = '0;
                        state_d = SEARCH;
                    end
                end
                LOCKED: begin
                    // Prediction free-runs so a corrupted word never corrupts ref.
                    ref_d = pred;
                    if (hit) begin
                        miss_d = '0;
                    end else begin
                        pulse_d = 1'b1;
                        miss_d  = miss_q + 4'd1;
                        wcnt_d  = (wcnt_q == 16'hFFFF) ? wcnt_q : wcnt_q + 16'd1;
`ifdef PRBS_CHECKER_BITCNT_EN
                        bcnt_d  = bsum[32] ? 32'hFFFF_FFFF : bsum[31:0];
`endif
                        if (miss_q + 4'd1 == LOSS_TGT) begin
                            state_d = SEARCH;
                            miss_d  = '0;
                        end
                    end
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end
        // Clear takes priority over an error counted in the same cycle.
        if (clr_cnt) begin
            wcnt_d = '0;
`ifdef PRBS_CHECKER_BITCNT_EN
            bcnt_d = '0;
`endif
        end
        locked_d = (state_d == LOCKED);
    end

    // State, reference and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= SEARCH;
            ref_q    <= '0;
            match_q  <= '0;
            miss_q   <= '0;
            locked_q <= 1'b0;
            pulse_q  <= 1'b0;
            wcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            ref_q    <= ref_d;
            match_q  <= match_d;
            miss_q   <= miss_d;
            locked_q <= locked_d;
            pulse_q  <= pulse_d;
            wcnt_q   <= wcnt_d;
        end
    end

`ifdef PRBS_CHECKER_BITCNT_EN
    // Mismatched-bit accumulator.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcnt_q <= '0;
        end else begin
            bcnt_q <= bcnt_d;
        end
    end

    assign err_bit_cnt = bcnt_q;
`else
    assign err_bit_cnt = '0;
`endif

    assign locked       = locked_q;
    assign err_pulse    = pulse_q;
    assign err_word_cnt = wcnt_q;
    assign dbg_state    = state_q;

endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 Parameter LOCK_CNT, default 4: consecutive correct predictions required to declare lock (legal range 1..15).
REQ-002 Parameter LOSS_CNT, default 4: consecutive mispredictions while locked that force loss of lock (legal range 1..15).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 din  input  32  received PRBS word.
REQ-006 din_valid  input  1  din is sampled this cycle.
REQ-007 clr_cnt  input  1  synchronous clear of the error counter.
REQ-008 locked  output  1  checker is in LOCKED state.
REQ-009 err_pulse  output  1  one-cycle pulse for each mispredicted word while locked.
REQ-010 err_word_cnt  output  16  saturating count of mispredicted words while locked.
REQ-011 err_bit_cnt  output  32  saturating count of mismatched bits while locked (see Configuration).

Function
REQ-012 The prediction function N(q) SHALL be: N[0]=q[1]^q[0]; N[1]=q[2]^q[0]; N[i]=q[i+1] for i=2..20; N[21]=q[22]^q[0]; N[i]=q[i+1] for i=22..30; N[31]=q[0].
REQ-013 FSM states SHALL be SEARCH, VERIFY and LOCKED; an internal 32-bit register ref holds the last accepted or predicted word.
REQ-014 Cycles with din_valid=0 SHALL leave all state, ref and counters unchanged and SHALL drive err_pulse=0.
REQ-015 SEARCH: a valid nonzero din SHALL load ref<=din, clear the match count and move to VERIFY; a valid din=0 SHALL be ignored.
REQ-016 VERIFY: if din==N(ref), ref<=din and the match count increments; reaching LOCK_CNT matches SHALL move to LOCKED in the same update.
REQ-017 VERIFY mismatch: a nonzero din SHALL give ref<=din, match count 0, state VERIFY; din=0 SHALL give state SEARCH.
REQ-018 LOCKED: ref<=N(ref) on every valid word, regardless of din (free-running prediction).
REQ-019 LOCKED mismatch (din!=N(ref)): err_pulse=1 on the next cycle, err_word_cnt increments (saturating at 0xFFFF) and the miss count increments; a match SHALL clear the miss count.
REQ-020 Reaching LOSS_CNT consecutive misses SHALL move to SEARCH, with locked=0 on the next cycle; the word that triggers the loss SHALL still be counted.
REQ-021 All outputs SHALL be registered; the response to a valid word is visible exactly 1 cycle after it is sampled.
REQ-022 clr_cnt=1 SHALL zero err_word_cnt and err_bit_cnt; if an error occurs in the same cycle, the clear wins and the counter reads 0; FSM, ref and err_pulse are unaffected.
REQ-023 Mismatches in SEARCH or VERIFY SHALL NOT affect err_pulse or the counters.

Reset
REQ-024 Reset assertion SHALL immediately force state=SEARCH, ref=0, match and miss counts 0, locked=0, err_pulse=0, err_word_cnt=0 and err_bit_cnt=0.
REQ-025 Reset asserted mid-lock SHALL discard lock; after release the checker re-acquires from SEARCH.

Configuration
REQ-026 Macro PRBS_CHECKER_BITCNT_EN defined: err_bit_cnt accumulates popcount(din ^ N(ref)) per LOCKED mismatch, saturating at 0xFFFFFFFF.
REQ-027 Macro PRBS_CHECKER_BITCNT_EN undefined: the port still exists, is tied to 0, and no popcount logic is built.

Verification
REQ-028 Reset, then valid words 0x00000001, 0x80200003, then the next 4 words of the sequence N applied -> locked=1 one cycle after the 5th word; err_word_cnt=0.
REQ-029 Locked stream with one word XOR 0x00000005 -> err_pulse high for exactly 1 cycle, err_word_cnt=1, err_bit_cnt=2 (macro on) or 0 (macro off), locked stays 1.
REQ-030 Locked, then 4 consecutive corrupted words -> err_word_cnt=4 and locked=0 after the 4th; a later clean stream re-locks after 1+LOCK_CNT words.
REQ-031 din=0 with din_valid=1 while in SEARCH -> state stays SEARCH, locked=0, no counter change.
REQ-032 Error word and clr_cnt=1 in the same cycle -> err_word_cnt=0, err_pulse=1; gaps in din_valid between words -> no state change.
REQ-033 reset pulled low asynchronously while locked -> locked=0 and counters 0 before the next clk edge.
